// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, imem req/ready handshake, one-entry skid, branch/jump redirect.
// Optional instruction counter output fetch_count, enabled with `define IF_FETCH_COUNT_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// FETCH | issuing/awaiting requests, delivering words to decode
// HOLD  | skid holds a word that arrived under stall, no request
// DRAIN | squashing an outstanding request before a redirect
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [31:0]           imem_rdata,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jump,
   input  logic [25:0]           jump_index,
   output logic [31:0]           instr,
   output logic [5:0]            opCode,
   output logic [ADDR_WIDTH-1:0] pc_plus4,
   output logic                  instr_valid
`ifdef IF_FETCH_COUNT_EN
   ,
   output logic [31:0]           fetch_count
`endif
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
   logic [31:0]           instr_q, instr_d;
   logic                  valid_q, valid_d;
   logic [31:0]           skid_instr_q, skid_instr_d;
   logic [ADDR_WIDTH-1:0] skid_pc4_q, skid_pc4_d;
   logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
   logic                  out_q, out_d;

   logic                  req_c;
   logic                  redirect;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] jmp_tgt;
   logic [ADDR_WIDTH-1:0] redir_tgt;

   // Jump keeps the region bits of the sequential successor of the current instr.
   generate
      if (ADDR_WIDTH > 28) begin : g_jmp_region
         assign jmp_tgt = {pc4_q[ADDR_WIDTH-1:28], jump_index, 2'b00};
      end else begin : g_jmp_flat
         assign jmp_tgt = {jump_index, 2'b00};
      end
   endgenerate

   assign redirect  = branch_taken | jump;
   assign redir_tgt = (branch_taken ? branch_target : jmp_tgt) & ALIGN_MASK;
   assign pc_inc    = pc_q + ADDR_WIDTH'(4);

   always_comb begin
      req_c = 1'b0;
      case (state_q)
         FETCH:   req_c = ~(stall & valid_q) | out_q;
         DRAIN:   req_c = 1'b1;
         default: req_c = 1'b0;
      endcase
   end

   assign imem_req  = req_c & rst_n;
   assign imem_addr = pc_q & ALIGN_MASK;
   assign accept    = imem_req & imem_ready;

   assign instr       = instr_q;
   assign opCode      = instr_q[31:26];
   assign pc_plus4    = pc4_q;
   assign instr_valid = valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc4_d        = pc4_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      tgt_d        = tgt_q;
      out_d        = imem_req & ~imem_ready;

      if (redirect) begin
         valid_d = 1'b0;
         instr_d = '0;
         // A request already on the bus must finish at its old address before retargeting.
         if (imem_req & ~imem_ready) begin
            state_d = DRAIN;
            tgt_d   = redir_tgt;
         end else begin
            state_d = FETCH;
            pc_d    = redir_tgt;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (accept) begin
                  pc_d = pc_inc;
                  if (~stall | ~valid_q) begin
                     instr_d = imem_rdata;
                     pc4_d   = pc_inc;
                     valid_d = 1'b1;
                  end else begin
                     skid_instr_d = imem_rdata;
                     skid_pc4_d   = pc_inc;
                     state_d      = HOLD;
                  end
               end else if (~stall) begin
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (~stall) begin
                  instr_d = skid_instr_q;
                  pc4_d   = skid_pc4_q;
                  valid_d = 1'b1;
                  state_d = FETCH;
               end
            end
            DRAIN: begin
               if (imem_ready) begin
                  pc_d    = tgt_q;
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         pc4_q        <= '0;
         instr_q      <= '0;
         valid_q      <= 1'b0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
         tgt_q        <= '0;
         out_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         tgt_q        <= tgt_d;
         out_q        <= out_d;
      end
   end

`ifdef IF_FETCH_COUNT_EN
   logic        load_out;
   logic [31:0] fetch_count_q;

   // New data reaches decode outputs either straight from memory or from the skid.
   assign load_out = ~redirect &
                     (((state_q == FETCH) & accept & (~stall | ~valid_q)) |
                      ((state_q == HOLD) & ~stall));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= '0;
      end else if (load_out) begin
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected fetch addresses and delivered words are
// queued as stimulus is planned and compared when the DUT accepts/delivers them.
module tb_instruction_fetch;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ready;
   logic [31:0]   imem_rdata;
   logic          stall;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          jump;
   logic [25:0]   jump_index;
   logic [31:0]   instr;
   logic [5:0]    opCode;
   logic [AW-1:0] pc_plus4;
   logic          instr_valid;
`ifdef IF_FETCH_COUNT_EN
   logic [31:0]   fetch_count;
`endif

   int vectors_applied = 0;
   int miscompares = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [63:0]   exp_out_q[$];

   always #5 clk = ~clk;

   instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_index    (jump_index),
      .instr         (instr),
      .opCode        (opCode),
      .pc_plus4      (pc_plus4),
      .instr_valid   (instr_valid)
`ifdef IF_FETCH_COUNT_EN
      ,
      .fetch_count   (fetch_count)
`endif
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[7:2], a[27:2] ^ 26'h2A55A5A};
   endfunction

   assign imem_rdata = word_of(imem_addr);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_fetch(input logic [31:0] a, input bit deliver);
      exp_addr_q.push_back(a);
      if (deliver) exp_out_q.push_back({word_of(a), a + 32'd4});
   endtask

   // One clock: score accepted requests and consumed words, then advance to the next negedge.
   task automatic cyc();
      logic [63:0] e;
      #1;
      if (rst_n) begin
         if (imem_req && imem_ready) begin
            if (exp_addr_q.size() == 0) check("unexpected_accept", 64'(imem_addr), 64'hFFFF_FFFF);
            else check("fetch_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
         end
         if (instr_valid && !stall) begin
            if (exp_out_q.size() == 0) begin
               check("unexpected_instr", 64'(instr), 64'hFFFF_FFFF_FFFF);
            end else begin
               e = exp_out_q.pop_front();
               check("instr", 64'(instr), 64'(e[63:32]));
               check("pc_plus4", 64'(pc_plus4), 64'(e[31:0]));
               check("opCode", 64'(opCode), 64'(e[63:58]));
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      imem_ready    = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      jump          = 1'b0;
      jump_index    = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_pc4", 64'(pc_plus4), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait streaming from RESET_PC
      for (int i = 0; i < 6; i++) begin
         push_fetch(32'(4 * i), 1'b1);
         cyc();
      end

      // Three wait states on 0x18: request and address must hold
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("wait_req", 64'(imem_req), 64'd1);
         check("wait_addr", 64'(imem_addr), 64'h18);
         cyc();
      end
      imem_ready = 1'b1;
      push_fetch(32'h18, 1'b1);
      cyc();

      // Stall while a request is outstanding; word must be held, then consumed exactly once
      imem_ready = 1'b0;
      cyc();
      stall = 1'b1;
      imem_ready = 1'b1;
      push_fetch(32'h1C, 1'b1);
      #1 check("stall_out_req", 64'(imem_req), 64'd1);
      cyc();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_req_low", 64'(imem_req), 64'd0);
         check("stall_instr_hold", 64'(instr), 64'(word_of(32'h1C)));
         check("stall_valid", 64'(instr_valid), 64'd1);
         cyc();
      end
      stall = 1'b0;
      push_fetch(32'h20, 1'b1);
      cyc();

      // Jump with same-cycle ready: response discarded, retarget to 0x40
      #1 check("pre_jump_pc4", 64'(pc_plus4), 64'h24);
      jump = 1'b1;
      jump_index = 26'h10;
      push_fetch(32'h24, 1'b0);
      cyc();
      jump = 1'b0;
      #1;
      check("jump_bubble_valid", 64'(instr_valid), 64'd0);
      check("jump_nop_instr", 64'(instr), 64'd0);
      check("jump_nop_opcode", 64'(opCode), 64'd0);
      push_fetch(32'h40, 1'b1);
      cyc();
      push_fetch(32'h44, 1'b1);
      cyc();

      // Branch (with simultaneous jump) while 0x48 is pending: DRAIN then 0x100
      imem_ready = 1'b0;
      branch_taken = 1'b1;
      branch_target = 32'h100;
      jump = 1'b1;
      jump_index = 26'h3FF;
      cyc();
      branch_taken = 1'b0;
      jump = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("drain_req", 64'(imem_req), 64'd1);
         check("drain_addr", 64'(imem_addr), 64'h48);
         check("drain_valid", 64'(instr_valid), 64'd0);
         cyc();
      end
      imem_ready = 1'b1;
      push_fetch(32'h48, 1'b0);
      cyc();
      push_fetch(32'h100, 1'b1);
      #1 check("post_drain_valid", 64'(instr_valid), 64'd0);
      cyc();
      push_fetch(32'h104, 1'b1);
      cyc();

      // Reset asserted in the middle of a DRAIN
      imem_ready = 1'b0;
      branch_taken = 1'b1;
      branch_target = 32'h200;
      cyc();
      branch_taken = 1'b0;
      #1;
      check("drain2_addr", 64'(imem_addr), 64'h108);
      rst_n = 1'b0;
      #1;
      check("midrst_req", 64'(imem_req), 64'd0);
      check("midrst_valid", 64'(instr_valid), 64'd0);
      check("midrst_instr", 64'(instr), 64'd0);
      check("midrst_pc4", 64'(pc_plus4), 64'd0);
      repeat (2) @(negedge clk);
      imem_ready = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_fetch(32'(4 * i), 1'b1);
         cyc();
      end
      stall = 1'b1;
      imem_ready = 1'b0;
      cyc();
      stall = 1'b0;
      cyc();

      check("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
      check("out_queue_empty", 64'(exp_out_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
